// File: rtl/tile_energy_accumulator.sv
// Per-tile energy integrator: turns DVFS frequency and dynamic/leakage power
// telemetry into saturating picojoule accumulators via a serial cycle-time divider.
module tile_energy_accumulator #(
  parameter int FREQ_W = 16,
  parameter int PWR_W  = 16,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [FREQ_W-1:0] freq_mhz,
  input  logic [PWR_W-1:0]  dyn_power_mw,
  input  logic [PWR_W-1:0]  leak_power_mw,
  output logic [19:0]       cycle_time_ps,
  output logic              ct_valid,
  output logic [ACC_W-1:0]  dynamic_energy_pj,
  output logic [ACC_W-1:0]  leakage_energy_pj,
  output logic [ACC_W-1:0]  energy_pj,
  output logic [31:0]       sample_count,
  output logic [31:0]       dropped_count,
  output logic              saturated
);

  localparam int CT_W   = 20;
  localparam int PROD_W = PWR_W + 1 + CT_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [CT_W-1:0]  DIVIDEND = 20'd1_000_000;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {IDLE, DIV} state_t;

  function automatic logic [PROD_W-1:0] div1000(input logic [PROD_W-1:0] p);
    return p / PROD_W'(1000);
  endfunction

  // Returns {clamped, value}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [PROD_W-1:0] incr);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(incr);
    if (s > SUM_W'(ACC_MAX)) return {1'b1, ACC_MAX};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  state_t            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [CT_W-1:0]   ct_q, ct_d;
  logic              ctv_q, ctv_d;
  logic [FREQ_W-1:0] rem_q, rem_d;
  logic [CT_W-1:0]   dsh_q, dsh_d;
  logic [4:0]        iter_q, iter_d;

  logic              freq_zero, freq_chg;
  logic [FREQ_W:0]   trial;
  logic              ge;
  logic [FREQ_W-1:0] diff;

  assign freq_zero = (freq_mhz == '0);
  assign freq_chg  = !freq_zero && (freq_mhz != freq_q);

  // Restoring divide step; dsh_q shifts the dividend out and the quotient in.
  assign trial = {rem_q, dsh_q[CT_W-1]};
  assign ge    = (trial >= {1'b0, freq_q});
  assign diff  = trial[FREQ_W-1:0] - freq_q;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    ct_d    = ct_q;
    ctv_d   = ctv_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    iter_d  = iter_q;
    if (freq_zero) begin
      state_d = IDLE;
      freq_d  = '0;
      ct_d    = '0;
      ctv_d   = 1'b1;
    end else if (freq_chg) begin
      state_d = DIV;
      freq_d  = freq_mhz;
      ctv_d   = 1'b0;
      rem_d   = '0;
      dsh_d   = DIVIDEND;
      iter_d  = '0;
    end else if (state_q == DIV) begin
      rem_d  = ge ? diff : trial[FREQ_W-1:0];
      dsh_d  = {dsh_q[CT_W-2:0], ge};
      iter_d = iter_q + 5'd1;
      if (iter_q == 5'd19) begin
        state_d = IDLE;
        ct_d    = {dsh_q[CT_W-2:0], ge};
        ctv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      freq_q  <= '0;
      ct_q    <= '0;
      ctv_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      ct_q    <= ct_d;
      ctv_q   <= ctv_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dsh_q  <= dsh_d;
    iter_q <= iter_d;
  end

  logic vld_p0, drop_p0, vld_p1;
  logic [PWR_W:0]    dyn_ext, leak_ext, sum_pw;
  logic [PROD_W-1:0] prod_dyn_p1, prod_leak_p1, prod_tot_p1;

  assign vld_p0   = enable && ctv_q && !clear && !freq_chg;
  assign drop_p0  = enable && !clear && (!ctv_q || freq_chg);
  assign dyn_ext  = {1'b0, dyn_power_mw};
  assign leak_ext = {1'b0, leak_power_mw};
  assign sum_pw   = dyn_ext + leak_ext;

  // S1: products against the currently registered cycle time.
  always_ff @(posedge clk) begin
    prod_dyn_p1  <= PROD_W'(dyn_ext) * PROD_W'(ct_q);
    prod_leak_p1 <= PROD_W'(leak_ext) * PROD_W'(ct_q);
    prod_tot_p1  <= PROD_W'(sum_pw) * PROD_W'(ct_q);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) vld_p1 <= 1'b0;
    else                vld_p1 <= vld_p0;
  end

  logic [ACC_W-1:0] dyn_acc, leak_acc, tot_acc;
  logic [ACC_W:0]   dyn_sum, leak_sum, tot_sum;
  logic [31:0]      smp_cnt, drp_cnt;
  logic             sat_q;

  always_comb begin
    dyn_sum  = sat_add(dyn_acc, div1000(prod_dyn_p1));
    leak_sum = sat_add(leak_acc, div1000(prod_leak_p1));
    tot_sum  = sat_add(tot_acc, div1000(prod_tot_p1));
  end

  // S2: scale and accumulate; clear overrides any write landing this edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dyn_acc  <= '0;
      leak_acc <= '0;
      tot_acc  <= '0;
      smp_cnt  <= '0;
      drp_cnt  <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (vld_p1) begin
        dyn_acc  <= dyn_sum[ACC_W-1:0];
        leak_acc <= leak_sum[ACC_W-1:0];
        tot_acc  <= tot_sum[ACC_W-1:0];
        smp_cnt  <= sat_inc(smp_cnt);
        if (dyn_sum[ACC_W] || leak_sum[ACC_W] || tot_sum[ACC_W]) sat_q <= 1'b1;
      end
      if (drop_p0) drp_cnt <= sat_inc(drp_cnt);
    end
  end

  assign cycle_time_ps     = ct_q;
  assign ct_valid          = ctv_q;
  assign dynamic_energy_pj = dyn_acc;
  assign leakage_energy_pj = leak_acc;
  assign energy_pj         = tot_acc;
  assign sample_count      = smp_cnt;
  assign dropped_count     = drp_cnt;
  assign saturated         = sat_q;

endmodule

// File: tb/tb_tile_energy_accumulator.sv
// Scoreboard bench for tile_energy_accumulator: directed telemetry vectors with
// hand-computed increments, plus a narrow-accumulator instance for clamping.
module tb_tile_energy_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, clear;
  logic [15:0] freq_mhz, dyn_power_mw, leak_power_mw;
  logic [19:0] cycle_time_ps;
  logic        ct_valid, saturated;
  logic [63:0] dynamic_energy_pj, leakage_energy_pj, energy_pj;
  logic [31:0] sample_count, dropped_count;

  logic        s_en, s_clr;
  logic [15:0] s_freq, s_dyn, s_leak;
  logic [19:0] s_ct;
  logic        s_ctv, s_sat;
  logic [15:0] s_dyn_e, s_leak_e, s_tot_e;
  logic [31:0] s_cnt, s_drop;

  tile_energy_accumulator #(.FREQ_W(16), .PWR_W(16), .ACC_W(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .freq_mhz(freq_mhz), .dyn_power_mw(dyn_power_mw), .leak_power_mw(leak_power_mw),
    .cycle_time_ps(cycle_time_ps), .ct_valid(ct_valid),
    .dynamic_energy_pj(dynamic_energy_pj), .leakage_energy_pj(leakage_energy_pj),
    .energy_pj(energy_pj), .sample_count(sample_count),
    .dropped_count(dropped_count), .saturated(saturated)
  );

  tile_energy_accumulator #(.FREQ_W(16), .PWR_W(16), .ACC_W(16)) dut_sat (
    .clk(clk), .reset(reset), .enable(s_en), .clear(s_clr),
    .freq_mhz(s_freq), .dyn_power_mw(s_dyn), .leak_power_mw(s_leak),
    .cycle_time_ps(s_ct), .ct_valid(s_ctv),
    .dynamic_energy_pj(s_dyn_e), .leakage_energy_pj(s_leak_e),
    .energy_pj(s_tot_e), .sample_count(s_cnt),
    .dropped_count(s_drop), .saturated(s_sat)
  );

  typedef struct {
    logic [63:0] dyn;
    logic [63:0] leak;
    logic [63:0] tot;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m_dyn, m_leak, m_tot;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_sample(input logic [63:0] di, input logic [63:0] li, input logic [63:0] ti);
    exp_t e;
    m_dyn  = m_dyn + di;
    m_leak = m_leak + li;
    m_tot  = m_tot + ti;
    m_cnt  = m_cnt + 1;
    e.dyn = m_dyn; e.leak = m_leak; e.tot = m_tot; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic model_zero();
    m_dyn = '0; m_leak = '0; m_tot = '0; m_cnt = '0;
  endtask

  task automatic wait_valid(output int lows);
    lows = 0;
    while (!ct_valid && lows < 40) begin
      lows++;
      tick();
    end
  endtask

  // Monitor: every new nonzero sample_count is a presented result.
  logic [31:0] last_cnt;
  exp_t        got;
  always @(negedge clk) begin
    if (sample_count !== last_cnt) begin
      if (sample_count != 0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_sample: got count %0d, required no new sample", sample_count);
        end else begin
          got = sb.pop_front();
          chk("sb_dyn",  dynamic_energy_pj, got.dyn);
          chk("sb_leak", leakage_energy_pj, got.leak);
          chk("sb_tot",  energy_pj,         got.tot);
          chk("sb_cnt",  64'(sample_count), 64'(got.cnt));
        end
      end
      last_cnt = sample_count;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  int lows;

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    freq_mhz = '0; dyn_power_mw = '0; leak_power_mw = '0;
    s_en = 1'b0; s_clr = 1'b0; s_freq = '0; s_dyn = '0; s_leak = '0;
    model_zero();
    tick(); tick();

    chk("rst_ct",    64'(cycle_time_ps), 0);
    chk("rst_ctv",   64'(ct_valid), 1);
    chk("rst_dyn",   dynamic_energy_pj, 0);
    chk("rst_leak",  leakage_energy_pj, 0);
    chk("rst_tot",   energy_pj, 0);
    chk("rst_cnt",   64'(sample_count), 0);
    chk("rst_drop",  64'(dropped_count), 0);
    chk("rst_sat",   64'(saturated), 0);
    reset = 1'b0;

    // Steady state at 1 GHz.
    freq_mhz = 16'd1000; dyn_power_mw = 16'd500; leak_power_mw = 16'd100;
    tick();
    chk("ss_ctv_drop", 64'(ct_valid), 0);
    wait_valid(lows);
    chk("ss_div_cycles", 64'(lows), 20);
    chk("ss_ct", 64'(cycle_time_ps), 1000);
    enable = 1'b1;
    repeat (200) begin
      push_sample(500, 100, 600);
      tick();
    end
    enable = 1'b0;
    tick(); tick();
    chk("ss_dyn",  dynamic_energy_pj, 100000);
    chk("ss_leak", leakage_energy_pj, 20000);
    chk("ss_tot",  energy_pj, 120000);
    chk("ss_cnt",  64'(sample_count), 200);
    chk("ss_drop", 64'(dropped_count), 0);

    // Truncation at 800 MHz.
    freq_mhz = 16'd800; dyn_power_mw = 16'd333; leak_power_mw = 16'd7;
    tick();
    wait_valid(lows);
    chk("tr_ct", 64'(cycle_time_ps), 1250);
    enable = 1'b1;
    push_sample(416, 8, 425);
    tick();
    enable = 1'b0;
    tick(); tick();
    chk("tr_tot", energy_pj, 120425);

    // Frequency change with enable held high.
    freq_mhz = 16'd1000; dyn_power_mw = 16'd500; leak_power_mw = 16'd100;
    tick();
    wait_valid(lows);
    chk("fc_ct_before", 64'(cycle_time_ps), 1000);
    freq_mhz = 16'd500; enable = 1'b1;
    tick();
    chk("fc_ctv_drop", 64'(ct_valid), 0);
    wait_valid(lows);
    chk("fc_div_cycles", 64'(lows), 20);
    chk("fc_ct", 64'(cycle_time_ps), 2000);
    push_sample(1000, 200, 1200);
    tick();
    enable = 1'b0;
    chk("fc_dropped", 64'(dropped_count), 21);
    tick(); tick();

    // Zero frequency: samples count but add no energy.
    freq_mhz = 16'd0;
    tick();
    chk("zf_ctv", 64'(ct_valid), 1);
    chk("zf_ct",  64'(cycle_time_ps), 0);
    enable = 1'b1;
    repeat (10) begin
      push_sample(0, 0, 0);
      tick();
    end
    enable = 1'b0;
    tick(); tick();
    chk("zf_cnt",  64'(sample_count), 212);
    chk("zf_tot",  energy_pj, 121625);
    chk("zf_drop", 64'(dropped_count), 21);

    // Clear against an in-flight sample, then against a same-edge sample.
    freq_mhz = 16'd1000;
    tick();
    wait_valid(lows);
    enable = 1'b1;
    tick();
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    chk("clr_dyn",  dynamic_energy_pj, 0);
    chk("clr_tot",  energy_pj, 0);
    chk("clr_cnt",  64'(sample_count), 0);
    chk("clr_drop", 64'(dropped_count), 0);
    chk("clr_sat",  64'(saturated), 0);
    chk("clr_ct_kept", 64'(cycle_time_ps), 1000);
    enable = 1'b1; clear = 1'b1;
    tick();
    enable = 1'b0; clear = 1'b0;
    tick();
    chk("clr_same_cnt", 64'(sample_count), 0);
    chk("clr_same_dyn", dynamic_energy_pj, 0);
    enable = 1'b1;
    push_sample(500, 100, 600);
    tick();
    enable = 1'b0;
    tick(); tick();
    chk("clr_after_dyn", dynamic_energy_pj, 500);

    // Reset in the middle of a divide.
    freq_mhz = 16'd250;
    tick();
    chk("rd_ctv_drop", 64'(ct_valid), 0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    model_zero();
    chk("rd_ct",  64'(cycle_time_ps), 0);
    chk("rd_ctv", 64'(ct_valid), 1);
    chk("rd_dyn", dynamic_energy_pj, 0);
    chk("rd_cnt", 64'(sample_count), 0);
    reset = 1'b0;
    tick();
    chk("rd_restart", 64'(ct_valid), 0);
    wait_valid(lows);
    chk("rd_div_cycles", 64'(lows), 20);
    chk("rd_ct_new", 64'(cycle_time_ps), 4000);

    // Saturation on the 16-bit accumulator instance.
    s_freq = 16'd1000; s_dyn = 16'd60000; s_leak = 16'd0;
    tick();
    lows = 0;
    while (!s_ctv && lows < 40) begin
      lows++;
      tick();
    end
    chk("sat_ct", 64'(s_ct), 1000);
    s_en = 1'b1;
    tick(); tick();
    s_en = 1'b0;
    chk("sat_first_dyn", 64'(s_dyn_e), 60000);
    chk("sat_first_flag", 64'(s_sat), 0);
    tick(); tick();
    chk("sat_dyn",  64'(s_dyn_e), 65535);
    chk("sat_tot",  64'(s_tot_e), 65535);
    chk("sat_leak", 64'(s_leak_e), 0);
    chk("sat_flag", 64'(s_sat), 1);
    chk("sat_cnt",  64'(s_cnt), 2);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("sat_clr_dyn",  64'(s_dyn_e), 0);
    chk("sat_clr_tot",  64'(s_tot_e), 0);
    chk("sat_clr_flag", 64'(s_sat), 0);
    chk("sat_clr_cnt",  64'(s_cnt), 0);

    tick();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_energy_accumulator.md
# tile_energy_accumulator

Per-tile energy integrator that converts the tile's per-cycle telemetry (DVFS frequency in MHz, dynamic and leakage power in mW) into cumulative picojoule counters. It sits directly downstream of the tile power manager / DVFS table and directly feeds the tile's `energy_estimate_pj`, `dynamic_energy_estimate_pj` and `leakage_energy_estimate_pj` outputs. The per-cycle increment for each channel is (power_mW × cycle_time_ps) / 1000, where cycle_time_ps = 1_000_000 / freq_MHz. All arithmetic is integer with truncation.

## Interface
- `FREQ_W`, default 16: frequency input width in MHz.
- `PWR_W`, default 16: power input width in mW.
- `ACC_W`, default 64: width of the energy accumulators in pJ.
- `clk`, input, 1 bit: single clock.
- `reset`, input, 1 bit: synchronous, active-high.
- `enable`, input, 1 bit: the current cycle is a telemetry sample.
- `clear`, input, 1 bit: synchronous clear of the counters.
- `freq_mhz`, input, FREQ_W bits: current DVFS frequency.
- `dyn_power_mw`, input, PWR_W bits: dynamic power.
- `leak_power_mw`, input, PWR_W bits: leakage power.
- `cycle_time_ps`, output, 20 bits: latched quotient 1_000_000 / freq.
- `ct_valid`, output, 1 bit: `cycle_time_ps` matches the latched frequency.
- `dynamic_energy_pj`, output, ACC_W bits: dynamic energy accumulator.
- `leakage_energy_pj`, output, ACC_W bits: leakage energy accumulator.
- `energy_pj`, output, ACC_W bits: total energy accumulator.
- `sample_count`, output, 32 bits: samples accumulated.
- `dropped_count`, output, 32 bits: samples dropped while `ct_valid` = 0.
- `saturated`, output, 1 bit: sticky flag; any accumulator has clamped.

## Operation
- **Reset values:** all accumulators and counts = 0; `saturated` = 0; latched freq = 0; `cycle_time_ps` = 0; `ct_valid` = 1; FSM in IDLE; pipeline empty.
- **Cycle-time FSM (IDLE / DIV):**
  - IDLE → DIV when `freq_mhz` ≠ latched freq and `freq_mhz` ≠ 0.
    - On that edge: latch the new freq, drop `ct_valid` to 0, start a 20-iteration restoring divide of 1_000_000 by the latched freq.
  - DIV → IDLE after 20 iterations: write the quotient to `cycle_time_ps` and set `ct_valid` = 1.
  - DIV, freq changes again: abort and restart with the new value. The full 20 cycles are counted again.
  - `freq_mhz` = 0 from any state: latch 0, set `cycle_time_ps` = 0 and `ct_valid` = 1 in the same edge, abort any divide.
- **Sample acceptance:** a sample is accepted when `enable` = 1 and `ct_valid` = 1 (registered value) and `clear` = 0 and the FSM does not detect a freq change that edge.
  - When `enable` = 1 and `ct_valid` = 0, or a freq change is detected: increment `dropped_count` (saturating).
  - When `enable` = 1 and `clear` = 1: the sample is discarded and `dropped_count` is not incremented.
- **Pipeline for an accepted sample:**
  - S1: register the three products, each PWR_W+1 by 20 bits = 37 bits: dyn×ct, leak×ct, (dyn+leak)×ct. The total is computed from the 17-bit sum, not from dyn_incr+leak_incr.
  - S2: each product divided by the constant 1000, truncated; zero-extended to ACC_W and added to its accumulator.
  - `sample_count` increments in S2.
- **Truncation:** total increment may exceed dyn_incr + leak_incr by at most 1. This is intentional.
- **Saturation:** each accumulator clamps at 2^ACC_W−1. `saturated` is set and stays set until `clear` or `reset`. The counts saturate at 2^32−1.
- **`clear`:**
  - Zeros the accumulators, both counts and `saturated`.
  - Flushes S1; an in-flight sample is lost.
  - Does not touch the FSM or `cycle_time_ps`.
  - Clear wins over a simultaneous S2 write.

## Timing
- **Accumulator latency:** sample accepted at edge N → accumulators and `sample_count` reflect it after edge N+1. Throughput is 1 sample per cycle.
- **Freq change:** change detected at edge N → `ct_valid` = 0 after N. The new `cycle_time_ps` and `ct_valid` = 1 appear after edge N+20. With `enable` held high, samples at edges N..N+20 are dropped: 21 drops.
- **Pipeline vs. cycle time:** an S1 entry captured before a freq change uses the old cycle time. S1/S2 are never stalled.
- **Reset mid-divide:** returns to IDLE with latched freq 0. A nonzero `freq_mhz` then restarts the divide on the first edge after reset deasserts.

## Test plan
- **Steady state:** freq=1000, dyn=500, leak=100; wait for `ct_valid`, then enable for 200 cycles → `cycle_time_ps`=1000; after pipeline drain dyn=100000, leak=20000, total=120000, `sample_count`=200.
- **Truncation:** freq=800, dyn=333, leak=7, one sample → `cycle_time_ps`=1250; dyn incr 416, leak incr 8, total incr 425.
- **Freq change under enable:** 1000→500 with enable held high → `ct_valid` low for exactly 20 cycles; `dropped_count`=21; `cycle_time_ps`=2000; next sample with dyn=500 adds 1000.
- **Zero freq:** freq=0, dyn=500, 10 samples → `ct_valid` stays 1, all accumulators unchanged, `sample_count` +10, `dropped_count` unchanged.
- **Saturation:** ACC_W=16, freq=1000, dyn=60000, two samples → `dynamic_energy_pj`=65535, `saturated`=1; then `clear` → all 0 and `saturated`=0.
- **Disruptions:** `clear` coinciding with an accepted sample → counters 0 and sample lost; `reset` mid-DIV → outputs return to reset values and the divide restarts after release.
